// File: rtl/shift_sequencer_if.sv
// Command-side bus of the shift sequencer.
//
// Handshake: the master presents start together with data_in, amount, dir
// and kind. The command is taken at the first rising edge where start=1 and
// busy=0. While busy=1, start is ignored and nothing is queued. done is a
// single-cycle pulse, and result is valid in that same cycle. result then
// keeps the last completed value until the next completion. abort cancels an
// operation that is still loading or shifting.
//
// Signals:
//   start    master->slave  command request
//   data_in  master->slave  operand (WIDTH)
//   amount   master->slave  requested shift count (AMT_W)
//   dir      master->slave  0 = right, 1 = left
//   kind     master->slave  00 logical, 01 arithmetic, 10 rotate, 11 logical
//   abort    master->slave  cancel in-progress operation
//   busy     slave->master  high whenever the sequencer is not idle
//   done     slave->master  one-cycle completion pulse
//   result   slave->master  operation result (WIDTH)
interface shift_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [AMT_W-1:0] amount;
    logic             dir;
    logic [1:0]       kind;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, data_in, amount, dir, kind, abort,
        input  busy, done, result
    );

    modport slave (
        input  start, data_in, amount, dir, kind, abort,
        output busy, done, result
    );
endinterface

// File: rtl/shift_sequencer.sv
// Sequencer for an external Mode-controlled shift register. It accepts one
// shift command, parallel-loads the operand, and issues n single-bit shifts
// with the serial-in bits chosen for logical, arithmetic or rotate semantics.
// It then reports the register contents with a done pulse.
//
// Ports:
//   Clk        clock, rising edge
//   Reset      synchronous, active-low
//   cmd        command bus (shift_sequencer_if.slave)
//   sr_q       shift register parallel output (fed back)
//   sr_mode    register mode: 00 hold, 01 right, 10 left, 11 load
//   sr_pin     register parallel input
//   sr_ls_in   left-shift serial input (enters LSB)
//   sr_rs_in   right-shift serial input (enters MSB)
//   state_dbg  current FSM state (0 idle, 1 load, 2 shift, 3 done)
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic                Clk,
    input  logic                Reset,
    shift_sequencer_if.slave    cmd,
    input  logic [WIDTH-1:0]    sr_q,
    output logic [1:0]          sr_mode,
    output logic [WIDTH-1:0]    sr_pin,
    output logic                sr_ls_in,
    output logic                sr_rs_in,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [1:0] KIND_ARITH = 2'b01;
    localparam logic [1:0] KIND_ROT   = 2'b10;

    localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);
    localparam logic [31:0]      WIDTH_U = WIDTH;

    state_t           state;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] lat_data;
    logic             lat_dir;
    logic [1:0]       lat_kind;
    logic [WIDTH-1:0] result_hold;
    logic             busy_q;
    logic             done_q;
    logic [AMT_W-1:0] n_eff;

    // Rotates wrap modulo WIDTH. Logical and arithmetic shifts saturate at
    // WIDTH, because the register is fully filled by then. The reserved kind
    // falls through to the logical rule.
    always_comb begin
        n_eff = cmd.amount;
        if (cmd.kind == KIND_ROT) begin
            n_eff = AMT_W'({{(32-AMT_W){1'b0}}, cmd.amount} % WIDTH_U);
        end else if (cmd.amount > WIDTH_A) begin
            n_eff = WIDTH_A;
        end
    end

    // The effective count is captured straight into the counter at
    // acceptance. LOAD only needs to test it for zero.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            lat_data    <= '0;
            lat_dir     <= 1'b0;
            lat_kind    <= '0;
            result_hold <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd.start) begin
                        lat_data <= cmd.data_in;
                        lat_dir  <= cmd.dir;
                        lat_kind <= cmd.kind;
                        cnt      <= n_eff;
                        state    <= S_LOAD;
                        busy_q   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (cmd.abort) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else if (cnt == '0) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end else begin
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // An abort on the final shift still lets that shift land in
                    // the register, because the mode is already driven. Only
                    // the done pulse is suppressed.
                    if (cmd.abort) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - AMT_W'(1);
                        if (cnt == AMT_W'(1)) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    result_hold <= sr_q;
                    state       <= S_IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        sr_mode  = MODE_HOLD;
        sr_pin   = '0;
        sr_ls_in = 1'b0;
        sr_rs_in = 1'b0;
        case (state)
            S_LOAD: begin
                sr_mode = MODE_LOAD;
                sr_pin  = lat_data;
            end
            S_SHIFT: begin
                if (lat_dir) begin
                    // An arithmetic left shift is identical to a logical left shift.
                    sr_mode  = MODE_LEFT;
                    sr_ls_in = (lat_kind == KIND_ROT) ? sr_q[WIDTH-1] : 1'b0;
                end else begin
                    sr_mode = MODE_RIGHT;
                    case (lat_kind)
                        KIND_ARITH: sr_rs_in = sr_q[WIDTH-1];
                        KIND_ROT:   sr_rs_in = sr_q[0];
                        default:    sr_rs_in = 1'b0;
                    endcase
                end
            end
            default: begin
                sr_mode = MODE_HOLD;
            end
        endcase
    end

    assign cmd.busy   = busy_q;
    assign cmd.done   = done_q;
    assign cmd.result = done_q ? sr_q : result_hold;
    assign state_dbg  = state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer. It contains a model of the controlled shift
// register. Expected results come from whole-word arithmetic on the operand,
// and the expected timing comes from the n+2 cycle latency rule.
module tb_shift_sequencer;
    localparam int W = 4;
    localparam int A = 3;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sr_q  = '0;
    logic [1:0]   sr_mode;
    logic [W-1:0] sr_pin;
    logic         sr_ls_in;
    logic         sr_rs_in;
    logic [1:0]   state_dbg;

    int           err_cnt = 0;
    int           chk_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_res = '0;

    shift_sequencer_if #(.WIDTH(W), .AMT_W(A)) bus ();

    shift_sequencer #(.WIDTH(W), .AMT_W(A)) dut (
        .Clk       (clk),
        .Reset     (rst_n),
        .cmd       (bus),
        .sr_q      (sr_q),
        .sr_mode   (sr_mode),
        .sr_pin    (sr_pin),
        .sr_ls_in  (sr_ls_in),
        .sr_rs_in  (sr_rs_in),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Controlled register: mode 01 shifts right with sr_rs_in entering the
    // MSB, mode 10 shifts left with sr_ls_in entering the LSB.
    always @(posedge clk) begin
        case (sr_mode)
            2'b11:   sr_q <= sr_pin;
            2'b01:   sr_q <= {sr_rs_in, sr_q[W-1:1]};
            2'b10:   sr_q <= {sr_q[W-2:0], sr_ls_in};
            default: sr_q <= sr_q;
        endcase
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int eff_n(input logic [A-1:0] a, input logic [1:0] k);
        int ai = int'(a);
        if (k == 2'b10) return ai % W;
        return (ai > W) ? W : ai;
    endfunction

    function automatic logic [W-1:0] ref_res(input logic [W-1:0] d, input int n,
                                             input logic dr, input logic [1:0] k);
        logic [2*W-1:0] dd;
        dd = {d, d};
        if (k == 2'b10) begin
            if (dr) return W'((dd << n) >> W);
            return W'(dd >> n);
        end
        if (dr) return W'(d << n);
        if (k == 2'b01) return W'($signed(d) >>> n);
        return W'(d >> n);
    endfunction

    // ---------------- drivers ----------------
    // Call this at posedge+1 while the DUT is idle. It returns at
    // posedge+1 of the acceptance edge, so the caller is in the LOAD cycle.
    task automatic issue(input logic [W-1:0] d, input logic [A-1:0] a,
                         input logic dr, input logic [1:0] k);
        bus.start   = 1'b1;
        bus.data_in = d;
        bus.amount  = a;
        bus.dir     = dr;
        bus.kind    = k;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_cmd(input logic [W-1:0] d, input logic [A-1:0] a,
                           input logic dr, input logic [1:0] k, input bit poke);
        int n;
        logic [W-1:0] exp;
        n = eff_n(a, k);
        exp_q.push_back(ref_res(d, n, dr, k));
        issue(d, a, dr, k);
        @(negedge clk);
        check("load_mode", 32'(sr_mode), 32'(3));
        check("load_busy", 32'(bus.busy), 32'(1));
        check("load_pin", 32'(sr_pin), 32'(d));
        for (int e = 1; e <= n + 1; e++) begin
            @(posedge clk);
            #1;
            if (poke && e == 1) begin
                bus.start   = 1'b1;
                bus.data_in = ~d;
                bus.amount  = '0;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (e <= n) begin
                check("shift_mode", 32'(sr_mode), 32'(dr ? 2 : 1));
                check("shift_done", 32'(bus.done), 32'(0));
            end else begin
                check("done_pulse", 32'(bus.done), 32'(1));
                check("done_mode", 32'(sr_mode), 32'(0));
                exp = exp_q.pop_front();
                check("result", 32'(bus.result), 32'(exp));
                last_res = exp;
            end
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'(0));
        check("idle_done", 32'(bus.done), 32'(0));
        check("result_hold", 32'(bus.result), 32'(last_res));
    endtask

    // Abort is raised during cycle ab_e after acceptance. Cycle 0 is LOAD and
    // cycle e >= 1 is the e-th shift, so the register ends up shifted ab_e times.
    task automatic abort_cmd(input logic [W-1:0] d, input logic [A-1:0] a,
                             input logic dr, input logic [1:0] k, input int ab_e);
        logic [W-1:0] part;
        part = ref_res(d, ab_e, dr, k);
        issue(d, a, dr, k);
        if (ab_e == 0) bus.abort = 1'b1;
        for (int e = 1; e <= ab_e; e++) begin
            @(posedge clk);
            #1;
            if (e == ab_e) bus.abort = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'(0));
        check("abort_done", 32'(bus.done), 32'(0));
        check("abort_mode", 32'(sr_mode), 32'(0));
        check("abort_result", 32'(bus.result), 32'(last_res));
        check("abort_sr_q", 32'(sr_q), 32'(part));
        @(posedge clk);
        @(negedge clk);
        check("abort_nodone", 32'(bus.done), 32'(0));
        check("abort_hold", 32'(sr_q), 32'(part));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid(input logic [W-1:0] d, input logic [A-1:0] a,
                             input logic dr, input logic [1:0] k);
        issue(d, a, dr, k);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_mode", 32'(sr_mode), 32'(0));
        check("rst_pin", 32'(sr_pin), 32'(0));
        check("rst_ls", 32'(sr_ls_in), 32'(0));
        check("rst_rs", 32'(sr_rs_in), 32'(0));
        check("rst_result", 32'(bus.result), 32'(0));
        rst_n = 1'b1;
        last_res = '0;
        @(posedge clk);
        @(negedge clk);
        check("rst_after_done", 32'(bus.done), 32'(0));
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int sel;
        logic [W-1:0] d;
        logic [A-1:0] a;
        logic dr;
        logic [1:0] k;

        bus.start   = 1'b0;
        bus.data_in = '0;
        bus.amount  = '0;
        bus.dir     = 1'b0;
        bus.kind    = '0;
        bus.abort   = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'(0));
        check("reset_done", 32'(bus.done), 32'(0));
        check("reset_mode", 32'(sr_mode), 32'(0));
        check("reset_result", 32'(bus.result), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_cmd(4'b1011, 3'd1, 1'b0, 2'b00, 1'b0);   // 0101
        run_cmd(4'b1000, 3'd2, 1'b0, 2'b01, 1'b0);   // 1110
        run_cmd(4'b0110, 3'd5, 1'b1, 2'b10, 1'b0);   // rotate left by 1 -> 1100
        run_cmd(4'b1111, 3'd6, 1'b1, 2'b00, 1'b0);   // clamped to 4 -> 0000
        run_cmd(4'b1010, 3'd0, 1'b0, 2'b00, 1'b0);   // no shifts -> 1010
        run_cmd(4'b0011, 3'd2, 1'b1, 2'b00, 1'b1);   // start while busy ignored -> 1100
        run_cmd(4'b1001, 3'd1, 1'b0, 2'b00, 1'b0);   // next start accepted -> 0100
        run_cmd(4'b1100, 3'd7, 1'b0, 2'b11, 1'b0);   // reserved kind, clamp -> 0000
        run_cmd(4'b1000, 3'd7, 1'b0, 2'b01, 1'b0);   // arithmetic clamp -> 1111
        run_cmd(4'b1001, 3'd4, 1'b0, 2'b10, 1'b1);   // rotate by WIDTH -> 0 shifts

        abort_cmd(4'b0001, 3'd3, 1'b0, 2'b10, 1);    // sr_q 1000
        abort_cmd(4'b0101, 3'd2, 1'b1, 2'b00, 2);    // abort on the last shift
        abort_cmd(4'b0110, 3'd3, 1'b0, 2'b00, 0);    // abort in LOAD
        reset_mid(4'b0001, 3'd3, 1'b0, 2'b10);
        run_cmd(4'b0111, 3'd1, 1'b1, 2'b01, 1'b0);   // 1110 after reset

        for (int i = 0; i < 60; i++) begin
            d   = W'($urandom_range(0, 15));
            a   = A'($urandom_range(0, 7));
            dr  = 1'($urandom_range(0, 1));
            k   = 2'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 9));
            n   = eff_n(a, k);
            if (sel < 7) run_cmd(d, a, dr, k, sel == 6);
            else abort_cmd(d, a, dr, k, int'($urandom_range(0, n)));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
